emu_cass_player: RTL and testbench
==================================

Name: emu_cass_player

Overview:
- Playback engine for the cassette emulator, directly upstream of the cassette output mux.
- Reads a tape image byte-by-byte from the cassette buffer RAM and serialises it into the Laser310 pulse-width cassette waveform.
- Drives EMU_CASS_EN / EMU_CASS_DAT; the mux selects emulated data over the CPU latch whenever EMU_CASS_EN=1.
- Started and stopped by the F9 (PLAY) / F10 (STOP) key pulses.

Parameters:
- ADDR_W, 16, cassette buffer address width; LENGTH and BUF_A use it.
- SHORT_HALF, 1500, clock cycles per half of a short cycle at normal speed (10 MHz).
- LONG_HALF, 3000, clock cycles per half of a long cycle at normal speed; must be ≥ 2.
- LEAD_OUT, 10000, idle-low cycles held after the last bit before EN drops.

Ports:
- CLK10MHZ  in  1  system clock, 10 MHz.
- RESET_N  in  1  asynchronous active-low reset.
- PLAY  in  1  one-cycle start pulse (F9).
- STOP  in  1  one-cycle abort pulse (F10).
- TURBO_SPEED  in  1  1 = all half-periods halved (count >>1).
- LENGTH  in  ADDR_W  image length in bytes; sampled on accepted PLAY.
- BUF_RD  out  1  read strobe to cassette buffer RAM.
- BUF_A  out  ADDR_W  buffer read address.
- BUF_Q  in  8  RAM read data; valid exactly 1 cycle after BUF_RD.
- EMU_CASS_EN  out  1  emulated tape active.
- EMU_CASS_DAT  out  2  {level, 1'b0}; same encoding as the CPU cassette latch.
- BUSY  out  1  playback in progress.
- DONE  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset values: BUF_RD=0, BUF_A=0, EMU_CASS_EN=0, EMU_CASS_DAT=2'b00, BUSY=0, DONE=0. All FSM state returns to IDLE.
- Bit encoding, MSB first:
  - Every bit starts with one short cycle: high for SH cycles, then low for SH cycles.
  - Bit 1 adds two more short cycles.
  - Bit 0 adds one long cycle: high for LH cycles, then low for LH cycles.
  - SH/LH = SHORT_HALF/LONG_HALF, or >>1 when TURBO_SPEED=1.
  - TURBO_SPEED is sampled at the start of each half-cycle, so a change mid-half-cycle takes effect at the next half-cycle.
- States:
  - IDLE: PLAY with LENGTH≠0 → FETCH. Latch LENGTH, set BUF_A=0, BUSY=1, EN=1, DAT=00.
  - IDLE: PLAY with LENGTH=0 → stay in IDLE; DONE pulses next cycle; EN is never asserted.
  - FETCH: BUF_RD=1 for one cycle → WAIT.
  - WAIT: one cycle → LOAD.
  - LOAD: capture BUF_Q into shift register; bit count=8 → BIT.
  - BIT: emit the bit waveform through the half-cycle timer. On bit end:
    - bits remain → shift and stay in BIT;
    - byte done and BUF_A+1 < LENGTH → increment BUF_A, go to FETCH;
    - otherwise → TAIL.
  - TAIL: DAT=00 for LEAD_OUT cycles → IDLE. On exit: EN=0, BUSY=0, DONE=1 for one cycle.
- Latency:
  - The first high edge of DAT appears 4 cycles after PLAY (IDLE→FETCH→WAIT→LOAD→BIT).
  - The 3-cycle refetch gap between bytes is held low.
  - Each bit period is fixed: 6·SH cycles for a 1, 2·SH+2·LH cycles for a 0.
- STOP:
  - In any non-IDLE state, the next cycle is IDLE with EN=0, DAT=00, BUSY=0, BUF_RD=0, and no DONE.
  - STOP together with PLAY: STOP wins.
- PLAY while BUSY is ignored.
- Address never wraps. The last read address is LENGTH-1; LENGTH = 2^ADDR_W-1 is the maximum.
- Reset asserted mid-playback forces all reset values immediately (asynchronous).

Decomposition:
- Shared package cass_pkg:
  - FSM state enum (IDLE, FETCH, WAIT, LOAD, BIT, TAIL);
  - DAT encoding constants CASS_HI=2'b10, CASS_LO=2'b00.
- One sub-module: cass_half_timer.
  - Loads a half-period count, decrements each cycle, pulses half_done on reaching 0.
  - The player sequences the short/long half-cycles from these pulses.

Test Plan:
- SH=4, LH=8, LEAD_OUT=16, LENGTH=1, BUF[0]=8'hA5, PLAY → DAT high at cycle 4 after PLAY; 8 bits of 24 cycles each (pattern 1,0,1,0,0,1,0,1 decoded by pulse counting); DONE 16 cycles after the last bit; EN low with DONE.
- LENGTH=3, image 00,FF,81 → BUF_RD pulses at addresses 0,1,2 only; 3-cycle low gap between bytes; the 24 decoded bits match.
- TURBO_SPEED=1 with SH=4, LH=8 → short half = 2 cycles, bit period = 12 cycles.
- STOP in the middle of byte 1 of a 3-byte image → next cycle EN=0, DAT=00, BUSY=0; no DONE; no further BUF_RD.
- LENGTH=0 PLAY → DONE pulse, EN never 1; PLAY while BUSY → no restart, BUF_A sequence unchanged.
- RESET_N pulsed low during BIT → all outputs at reset values within the same cycle; a subsequent PLAY replays from address 0.

Source files
------------

// File: rtl/emu_cass_player_pkg.sv
// Shared types and cassette-level encodings for the cassette playback engine.
package cass_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    BIT,
    TAIL
  } cass_state_e;

  // Same {level, 1'b0} encoding as the CPU cassette latch.
  localparam logic [1:0] CASS_HI = 2'b10;
  localparam logic [1:0] CASS_LO = 2'b00;

endpackage

// File: rtl/emu_cass_player_if.sv
// Control, buffer-RAM and cassette-output bundle of the playback engine.
interface emu_cass_player_if #(
  parameter int ADDR_W = 16
);
  logic              PLAY;
  logic              STOP;
  logic              TURBO_SPEED;
  logic [ADDR_W-1:0] LENGTH;
  logic              BUF_RD;
  logic [ADDR_W-1:0] BUF_A;
  logic [7:0]        BUF_Q;
  logic              EMU_CASS_EN;
  logic [1:0]        EMU_CASS_DAT;
  logic              BUSY;
  logic              DONE;

  modport master (
    output PLAY, STOP, TURBO_SPEED, LENGTH, BUF_Q,
    input  BUF_RD, BUF_A, EMU_CASS_EN, EMU_CASS_DAT, BUSY, DONE
  );

  modport slave (
    input  PLAY, STOP, TURBO_SPEED, LENGTH, BUF_Q,
    output BUF_RD, BUF_A, EMU_CASS_EN, EMU_CASS_DAT, BUSY, DONE
  );
endinterface

// File: rtl/emu_cass_player_half_timer.sv
// Down-counter timing one waveform half-cycle (or the lead-out); half_done marks its last cycle.
module cass_half_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_half_done
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  // A load of N gives exactly N cycles, the last of which raises half_done.
  assign o_half_done = r_active && (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_stop) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= i_count - {{(CNT_W-1){1'b0}}, 1'b1};
      r_active <= 1'b1;
    end else if (o_half_done) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      r_cnt    <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/emu_cass_player.sv
// Cassette playback engine: fetches tape-image bytes and serialises them MSB first
// into the Laser310 pulse-width waveform (1 = three short cycles, 0 = short + long).
module emu_cass_player
  import cass_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int SHORT_HALF = 1500,
  parameter int LONG_HALF  = 3000,
  parameter int LEAD_OUT   = 10000
) (
  input  logic             CLK10MHZ,
  input  logic             RESET_N,
  emu_cass_player_if.slave io
);
  localparam int MAXC = (LEAD_OUT > LONG_HALF)
                      ? ((LEAD_OUT > SHORT_HALF) ? LEAD_OUT : SHORT_HALF)
                      : ((LONG_HALF > SHORT_HALF) ? LONG_HALF : SHORT_HALF);
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] C_SH   = CNT_W'(SHORT_HALF);
  localparam logic [CNT_W-1:0] C_LH   = CNT_W'(LONG_HALF);
  localparam logic [CNT_W-1:0] C_LEAD = CNT_W'(LEAD_OUT);

  cass_state_e       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic [7:0]        r_shift;
  logic [3:0]        r_bitcnt;
  logic [2:0]        r_half;
  logic              r_buf_rd;
  logic              r_en;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_dat;

  logic              w_half_done;
  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_cnt;
  logic              w_stop;
  logic [CNT_W-1:0]  w_sh;
  logic [CNT_W-1:0]  w_lh;
  logic [2:0]        w_last_half;
  logic              w_bit_end;
  logic              w_byte_end;
  logic [ADDR_W:0]   w_next_addr;
  logic              w_more;
  logic              w_long_next;

  assign w_stop      = io.STOP && (r_state != IDLE);
  assign w_sh        = io.TURBO_SPEED ? (C_SH >> 1) : C_SH;
  assign w_lh        = io.TURBO_SPEED ? (C_LH >> 1) : C_LH;
  assign w_last_half = r_shift[7] ? 3'd5 : 3'd3;
  assign w_bit_end   = (r_state == BIT) && w_half_done && (r_half == w_last_half);
  assign w_byte_end  = w_bit_end && (r_bitcnt == 4'd1);
  assign w_next_addr = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_more      = w_next_addr < {1'b0, r_len};
  // Halves 2 and 3 of a 0 bit form the long cycle.
  assign w_long_next = !r_shift[7] && ((r_half == 3'd1) || (r_half == 3'd2));

  // Timer reloads on the same edge that ends the previous half, so halves abut.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_cnt  = w_sh;
    if (r_state == LOAD) begin
      w_tmr_load = 1'b1;
    end else if ((r_state == BIT) && w_half_done) begin
      w_tmr_load = 1'b1;
      if (!w_bit_end) begin
        w_tmr_cnt = w_long_next ? w_lh : w_sh;
      end else if (w_byte_end) begin
        if (w_more) w_tmr_load = 1'b0;
        else        w_tmr_cnt  = C_LEAD;
      end
    end
  end

  cass_half_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk       (CLK10MHZ),
    .i_rst_n     (RESET_N),
    .i_load      (w_tmr_load),
    .i_stop      (w_stop),
    .i_count     (w_tmr_cnt),
    .o_half_done (w_half_done)
  );

  always_ff @(posedge CLK10MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_half   <= '0;
      r_buf_rd <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dat    <= CASS_LO;
    end else begin
      r_buf_rd <= 1'b0;
      r_done   <= 1'b0;
      if (w_stop) begin
        r_state <= IDLE;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
        r_dat   <= CASS_LO;
      end else begin
        case (r_state)
          IDLE: if (io.PLAY && !io.STOP) begin
            if (io.LENGTH != '0) begin
              r_len    <= io.LENGTH;
              r_addr   <= '0;
              r_busy   <= 1'b1;
              r_en     <= 1'b1;
              r_dat    <= CASS_LO;
              r_buf_rd <= 1'b1;
              r_state  <= FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
          FETCH: r_state <= WAIT;
          // RAM data is only guaranteed in the cycle right after BUF_RD.
          WAIT: begin
            r_shift <= io.BUF_Q;
            r_state <= LOAD;
          end
          LOAD: begin
            r_bitcnt <= 4'd8;
            r_half   <= '0;
            r_dat    <= CASS_HI;
            r_state  <= BIT;
          end
          BIT: if (w_half_done) begin
            if (!w_bit_end) begin
              r_half <= r_half + 3'd1;
              r_dat  <= r_half[0] ? CASS_HI : CASS_LO;
            end else if (!w_byte_end) begin
              r_shift  <= r_shift << 1;
              r_bitcnt <= r_bitcnt - 4'd1;
              r_half   <= '0;
              r_dat    <= CASS_HI;
            end else if (w_more) begin
              r_addr   <= w_next_addr[ADDR_W-1:0];
              r_buf_rd <= 1'b1;
              r_dat    <= CASS_LO;
              r_state  <= FETCH;
            end else begin
              r_dat   <= CASS_LO;
              r_state <= TAIL;
            end
          end
          TAIL: if (w_half_done) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign io.BUF_RD       = r_buf_rd;
  assign io.BUF_A        = r_addr;
  assign io.EMU_CASS_EN  = r_en;
  assign io.EMU_CASS_DAT = r_dat;
  assign io.BUSY         = r_busy;
  assign io.DONE         = r_done;
endmodule

// File: tb/tb_emu_cass_player.sv
// Directed bench for emu_cass_player: waveform decoding, fetch sequence, stop/reset behaviour.
module tb_emu_cass_player;
  localparam int AW = 16;
  localparam int SH = 4;
  localparam int LH = 8;
  localparam int LO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  emu_cass_player_if #(.ADDR_W(AW)) io();

  emu_cass_player #(.ADDR_W(AW), .SHORT_HALF(SH), .LONG_HALF(LH), .LEAD_OUT(LO)) dut (
    .CLK10MHZ (clk),
    .RESET_N  (rst_n),
    .io       (io)
  );

  // Buffer RAM: data only valid in the cycle after BUF_RD, garbage otherwise.
  logic [7:0] mem [0:7];
  logic       rd_d = 1'b0;
  logic [7:0] q_r  = 8'h00;
  always @(posedge clk) begin
    rd_d <= io.BUF_RD;
    if (io.BUF_RD) q_r <= mem[io.BUF_A[2:0]];
  end
  assign io.BUF_Q = rd_d ? q_r : 8'h3C;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_play = 0;
  int highs[$];
  int lows[$];
  int rises[$];
  logic [AW-1:0] rd_addrs[$];
  int done_n = 0, done_cyc = 0, first_hi = -1, hi_len = 0, lo_len = 0, n_hi = 0;
  bit en_seen = 0, prev_hi = 0, en_at_done = 0, busy_at_done = 0, dat0_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (io.BUF_RD) rd_addrs.push_back(io.BUF_A);
    if (io.DONE) begin
      done_n++;
      done_cyc = cyc;
      en_at_done = io.EMU_CASS_EN;
      busy_at_done = io.BUSY;
    end
    if (io.EMU_CASS_EN) en_seen = 1;
    if (io.EMU_CASS_DAT[0]) dat0_seen = 1;
    if (io.EMU_CASS_DAT[1]) begin
      if (!prev_hi) begin
        rises.push_back(cyc);
        if (first_hi < 0) first_hi = cyc;
        if (n_hi > 0) lows.push_back(lo_len);
        hi_len = 0;
      end
      hi_len++;
    end else if (prev_hi) begin
      highs.push_back(hi_len);
      n_hi++;
      lo_len = 1;
    end else begin
      lo_len++;
    end
    prev_hi = io.EMU_CASS_DAT[1];
  end

  task automatic clear_logs();
    highs.delete(); lows.delete(); rises.delete(); rd_addrs.delete();
    done_n = 0; first_hi = -1; n_hi = 0; hi_len = 0; lo_len = 0; en_seen = 0;
  endtask

  task automatic play(input logic [AW-1:0] len);
    @(negedge clk); #1;
    io.LENGTH = len;
    io.PLAY = 1'b1;
    t_play = cyc;
    @(negedge clk); #1;
    io.PLAY = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n0;
    int k;
    n0 = done_n;
    k = 0;
    while (done_n == n0 && k < maxc) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (done_n == n0) begin
      failures++;
      $display("FAIL wait_done: no DONE within %0d cycles (required a DONE pulse)", maxc);
    end
  endtask

  // Pulse-count decoder: short pulse then long = 0, three short pulses = 1.
  task automatic decode(input int sw, output logic [31:0] bits, output int nb, output bit bad);
    int i;
    i = 0; bits = '0; nb = 0; bad = 0;
    while (i < highs.size()) begin
      if (highs[i] != sw) bad = 1;
      if (i + 1 < highs.size() && highs[i+1] == 2*sw) begin
        bits = {bits[30:0], 1'b0};
        i += 2;
      end else begin
        if (i + 2 >= highs.size() || highs[i+1] != sw || highs[i+2] != sw) bad = 1;
        bits = {bits[30:0], 1'b1};
        i += 3;
      end
      nb++;
    end
  endtask

  task automatic test_reset();
    io.PLAY = 0; io.STOP = 0; io.TURBO_SPEED = 0; io.LENGTH = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({io.BUF_RD, io.BUF_A, io.EMU_CASS_EN, io.EMU_CASS_DAT, io.BUSY, io.DONE} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%b a=%h en=%b dat=%b busy=%b done=%b, required all zero",
               io.BUF_RD, io.BUF_A, io.EMU_CASS_EN, io.EMU_CASS_DAT, io.BUSY, io.DONE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({io.EMU_CASS_EN, io.BUSY, io.DONE, io.BUF_RD} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got en=%b busy=%b done=%b rd=%b, required 0",
               io.EMU_CASS_EN, io.BUSY, io.DONE, io.BUF_RD);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] bits; int nb; bit bad;
    mem[0] = 8'hA5;
    clear_logs();
    play(16'd1);
    wait_done(400);
    decode(SH, bits, nb, bad);
    checks++;
    if (first_hi - t_play != 4) begin failures++; $display("FAIL first_high_latency: got %0d required 4", first_hi - t_play); end
    checks++;
    if (bits[7:0] !== 8'hA5 || nb != 8 || bad) begin failures++; $display("FAIL single_bits: got %h (n=%0d bad=%0d) required a5 n=8", bits[7:0], nb, bad); end
    checks++;
    if (rises.size() < 6 || rises[3] - rises[0] != 24 || rises[5] - rises[3] != 24) begin
      failures++; $display("FAIL bit_period: rises=%p required bit-1 and bit-0 periods of 24", rises);
    end
    checks++;
    if (done_cyc - t_play != 212) begin failures++; $display("FAIL single_done_time: got %0d required 212", done_cyc - t_play); end
    checks++;
    if (en_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      failures++; $display("FAIL en_busy_at_done: got en=%b busy=%b required 0 0", en_at_done, busy_at_done);
    end
    checks++;
    if (rd_addrs.size() != 1 || rd_addrs[0] != 0) begin failures++; $display("FAIL single_reads: got %p required {0}", rd_addrs); end
  endtask

  task automatic test_three_bytes();
    logic [31:0] bits; int nb; bit bad;
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h81;
    clear_logs();
    play(16'd3);
    wait_done(1000);
    decode(SH, bits, nb, bad);
    checks++;
    if (rd_addrs.size() != 3 || rd_addrs[0] != 0 || rd_addrs[1] != 1 || rd_addrs[2] != 2) begin
      failures++; $display("FAIL three_reads: got %p required {0,1,2}", rd_addrs);
    end
    checks++;
    if (bits[23:0] !== 24'h00FF81 || nb != 24 || bad) begin
      failures++; $display("FAIL three_bits: got %h (n=%0d bad=%0d) required 00ff81 n=24", bits[23:0], nb, bad);
    end
    checks++;
    if (lows.size() < 40 || lows[15] != LH + 3 || lows[39] != SH + 3) begin
      failures++; $display("FAIL refetch_gap: lows[15]/[39] not %0d/%0d (size=%0d)", LH + 3, SH + 3, lows.size());
    end
    checks++;
    if (done_cyc - t_play != 602) begin failures++; $display("FAIL three_done_time: got %0d required 602", done_cyc - t_play); end
  endtask

  task automatic test_turbo();
    logic [31:0] bits; int nb; bit bad;
    mem[0] = 8'hF0;
    io.TURBO_SPEED = 1'b1;
    clear_logs();
    play(16'd1);
    wait_done(400);
    io.TURBO_SPEED = 1'b0;
    decode(SH/2, bits, nb, bad);
    checks++;
    if (highs.size() < 1 || highs[0] != 2) begin failures++; $display("FAIL turbo_short_half: got %p required first 2", highs); end
    checks++;
    if (rises.size() < 15 || rises[3] - rises[0] != 12 || rises[14] - rises[12] != 12) begin
      failures++; $display("FAIL turbo_bit_period: rises=%p required 12-cycle bits", rises);
    end
    checks++;
    if (bits[7:0] !== 8'hF0 || nb != 8 || bad) begin failures++; $display("FAIL turbo_bits: got %h n=%0d bad=%0d required f0", bits[7:0], nb, bad); end
  endtask

  task automatic test_stop();
    int k; int nrd;
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h81;
    clear_logs();
    play(16'd3);
    k = 0;
    while (rd_addrs.size() < 2 && k < 500) begin @(negedge clk); #1; k++; end
    checks++;
    if (rd_addrs.size() < 2) begin failures++; $display("FAIL stop_reach_byte1: reads=%0d required 2", rd_addrs.size()); end
    repeat (30) @(negedge clk);
    #1; io.STOP = 1'b1;
    @(negedge clk); #1;
    io.STOP = 1'b0;
    checks++;
    if ({io.EMU_CASS_EN, io.EMU_CASS_DAT, io.BUSY, io.BUF_RD} !== 5'b0) begin
      failures++; $display("FAIL stop_outputs: got en=%b dat=%b busy=%b rd=%b required 0", io.EMU_CASS_EN, io.EMU_CASS_DAT, io.BUSY, io.BUF_RD);
    end
    nrd = rd_addrs.size();
    repeat (700) @(negedge clk);
    #1;
    checks++;
    if (done_n != 0 || nrd != 2 || rd_addrs.size() != 2) begin
      failures++; $display("FAIL stop_aftermath: done=%0d reads=%0d required done=0 reads=2", done_n, rd_addrs.size());
    end
    clear_logs();
    io.LENGTH = 16'd1; io.PLAY = 1'b1; io.STOP = 1'b1;
    @(negedge clk); #1;
    io.PLAY = 1'b0; io.STOP = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (io.BUSY !== 1'b0 || en_seen || rd_addrs.size() != 0 || done_n != 0) begin
      failures++; $display("FAIL stop_beats_play: busy=%b en_seen=%0d reads=%0d done=%0d required all 0", io.BUSY, en_seen, rd_addrs.size(), done_n);
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    play(16'd0);
    checks++;
    if (io.DONE !== 1'b1) begin failures++; $display("FAIL zero_len_done: got %b required 1", io.DONE); end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (done_n != 1 || en_seen || done_cyc - t_play != 1) begin
      failures++; $display("FAIL zero_len_misc: done=%0d en_seen=%0d dt=%0d required 1 0 1", done_n, en_seen, done_cyc - t_play);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits; int nb; bit bad; int t0;
    mem[0] = 8'h12; mem[1] = 8'h34;
    clear_logs();
    play(16'd2);
    t0 = t_play;
    repeat (50) @(negedge clk);
    play(16'd3);
    wait_done(1000);
    repeat (20) @(negedge clk);
    #1;
    decode(SH, bits, nb, bad);
    checks++;
    if (rd_addrs.size() != 2 || rd_addrs[0] != 0 || rd_addrs[1] != 1) begin
      failures++; $display("FAIL busy_play_reads: got %p required {0,1}", rd_addrs);
    end
    checks++;
    if (done_n != 1 || done_cyc - t0 != 407) begin
      failures++; $display("FAIL busy_play_done: done=%0d dt=%0d required 1 407", done_n, done_cyc - t0);
    end
    checks++;
    if (bits[15:0] !== 16'h1234 || nb != 16 || bad) begin failures++; $display("FAIL busy_play_bits: got %h required 1234", bits[15:0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits; int nb; bit bad;
    mem[0] = 8'h12; mem[1] = 8'h34;
    clear_logs();
    play(16'd2);
    repeat (40) @(negedge clk);
    #2; rst_n = 1'b0;
    #1;
    checks++;
    if ({io.BUF_RD, io.BUF_A, io.EMU_CASS_EN, io.EMU_CASS_DAT, io.BUSY, io.DONE} !== '0) begin
      failures++; $display("FAIL async_reset: got en=%b dat=%b busy=%b a=%h required 0", io.EMU_CASS_EN, io.EMU_CASS_DAT, io.BUSY, io.BUF_A);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    mem[0] = 8'h5A;
    clear_logs();
    play(16'd1);
    wait_done(400);
    decode(SH, bits, nb, bad);
    checks++;
    if (rd_addrs.size() != 1 || rd_addrs[0] != 0 || bits[7:0] !== 8'h5A || bad) begin
      failures++; $display("FAIL replay_after_reset: reads=%p bits=%h required {0} 5a", rd_addrs, bits[7:0]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_three_bytes();
    test_turbo();
    test_stop();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (dat0_seen) begin failures++; $display("FAIL dat_lsb: got DAT[0]=1 at some point, required always 0"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
